// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//
// MEM stage of an in-order RV32I pipeline. Issues one data memory access per
// load/store, stalls upstream while the access is outstanding, formats load
// data and stages all results in the MEM/WB pipeline register.
//
// Parameter
//    ACK_TIMEOUT   max cycles spent in WAIT before giving up (2..255)
//
// Optional feature (compile-time macro)
//    MEM_MISALIGN_CHECK_EN   defined: misaligned halfword/word accesses are
//                            not issued; misalign_o pulses and a bubble is
//                            written to MEM/WB. Undefined: the low address
//                            bits are ignored and misalign_o is tied 0.
//
// Ports
//    clk_i, rst_i                 clock, synchronous active-high reset
//    *_ex_mem_i                   EX/MEM pipeline fields (held by upstream
//                                 while busywait_o is high)
//    dmem_req_o .. dmem_wstrb_o   registered data memory request
//    dmem_rdata_i, dmem_ack_i     memory response (ack is a one-cycle pulse)
//    busywait_o                   combinational stall to upstream stages
//    *_mem_wb_o                   MEM/WB pipeline register
//    bus_err_o                    one-cycle pulse on ack timeout
//    misalign_o                   one-cycle pulse on misaligned access
// -----------------------------------------------------------------------------
module memory_access_stage #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] alu_out_ex_mem_i,
   input  logic [31:0] rs2_ex_mem_i,
   input  logic [4:0]  rd_ex_mem_i,
   input  logic [31:0] pc_ex_mem_i,
   input  logic [1:0]  wb_sel_ex_mem_i,
   input  logic [2:0]  funct3_ex_mem_i,
   input  logic        is_load_instr_ex_mem_i,
   input  logic        is_store_instr_ex_mem_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [29:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_wstrb_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i,
   output logic        busywait_o,
   output logic [4:0]  rd_mem_wb_o,
   output logic [31:0] alu_out_mem_wb_o,
   output logic [31:0] rd_data_mem_wb_o,
   output logic [31:0] pc_mem_wb_o,
   output logic [1:0]  wb_sel_mem_wb_o,
   output logic        is_load_instr_mem_wb_o,
   output logic        bus_err_o,
   output logic        misalign_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

   // Load formatting: pick the lane from the low address bits, then extend.
   // funct3[1:0] of 2'b1x (LW and the unused 011/110/111 codes) pass the word.
   function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [2:0]  f3);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = word >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b100:  fmt_load = {24'h000000, b};
         3'b101:  fmt_load = {16'h0000, h};
         default: fmt_load = word;
      endcase
   endfunction

   // Byte enables for a store of the given width at the given lane.
   function automatic logic [3:0] fmt_wstrb(input logic [1:0] lane,
                                            input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   fmt_wstrb = 4'b0001 << lane;
         2'b01:   fmt_wstrb = lane[1] ? 4'b1100 : 4'b0011;
         default: fmt_wstrb = 4'b1111;
      endcase
   endfunction

   // Store data replicated across all lanes so the strobes alone pick bytes.
   function automatic logic [31:0] fmt_wdata(input logic [31:0] data,
                                             input logic [2:0]  f3);
      case (f3[1:0])
         2'b00:   fmt_wdata = {4{data[7:0]}};
         2'b01:   fmt_wdata = {2{data[15:0]}};
         default: fmt_wdata = data;
      endcase
   endfunction

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] cnt_r;
   logic       mem_op_s;
   logic       misalign_s;
   logic       start_s;
   logic       ack_done_s;
   logic       timeout_fire_s;
   logic       misalign_fire_s;
   logic       busywait_s;
   logic       bubble_s;

   logic        req_r;
   logic        we_r;
   logic [29:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic        bus_err_r;
   logic [4:0]  rd_r;
   logic [31:0] alu_r;
   logic [31:0] rd_data_r;
   logic [31:0] pc_r;
   logic [1:0]  wb_sel_r;
   logic        is_load_r;

   // Access legality: only meaningful when the misalignment check is built in.
   always_comb begin
      mem_op_s   = is_load_instr_ex_mem_i | is_store_instr_ex_mem_i;
      misalign_s = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      if (mem_op_s) begin
         misalign_s = ((funct3_ex_mem_i[1:0] == 2'b01) && alu_out_ex_mem_i[0]) ||
                      (funct3_ex_mem_i[1] && (alu_out_ex_mem_i[1:0] != 2'b00));
      end else begin
         misalign_s = 1'b0;
      end
`endif
   end

   // Next-state logic and the stall/completion strobes derived from it.
   always_comb begin
      state_nxt_s     = state_r;
      busywait_s      = 1'b0;
      start_s         = 1'b0;
      ack_done_s      = 1'b0;
      timeout_fire_s  = 1'b0;
      misalign_fire_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A stray ack in IDLE is deliberately not looked at here.
            if (mem_op_s && !misalign_s) begin
               start_s     = 1'b1;
               busywait_s  = 1'b1;
               state_nxt_s = ST_WAIT;
            end else begin
               misalign_fire_s = misalign_s;
               state_nxt_s     = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Ack wins over timeout when both land on the last allowed cycle.
            if (dmem_ack_i) begin
               ack_done_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == TIMEOUT_LAST) begin
               timeout_fire_s = 1'b1;
               state_nxt_s    = ST_IDLE;
            end else begin
               busywait_s  = 1'b1;
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      // Dropped accesses must not reach writeback even though the pipe moves.
      bubble_s = busywait_s | timeout_fire_s | misalign_fire_s;
   end

   // State register and WAIT-cycle counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         if (start_s || ack_done_s || timeout_fire_s) begin
            cnt_r <= 8'd0;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 8'd1;
         end
      end
   end

   // Memory request register: fields captured on issue, held until done.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_r     <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= 30'd0;
         wdata_r   <= 32'd0;
         wstrb_r   <= 4'd0;
         bus_err_r <= 1'b0;
      end else begin
         bus_err_r <= timeout_fire_s;
         if (start_s) begin
            req_r   <= 1'b1;
            we_r    <= is_store_instr_ex_mem_i;
            addr_r  <= alu_out_ex_mem_i[31:2];
            wdata_r <= is_store_instr_ex_mem_i ?
                       fmt_wdata(rs2_ex_mem_i, funct3_ex_mem_i) : 32'd0;
            wstrb_r <= is_store_instr_ex_mem_i ?
                       fmt_wstrb(alu_out_ex_mem_i[1:0], funct3_ex_mem_i) : 4'd0;
         end else if (ack_done_s || timeout_fire_s) begin
            req_r <= 1'b0;
         end
      end
   end

   // MEM/WB pipeline register; rd and is_load are zeroed to form a bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_r      <= 5'd0;
         alu_r     <= 32'd0;
         rd_data_r <= 32'd0;
         pc_r      <= 32'd0;
         wb_sel_r  <= 2'd0;
         is_load_r <= 1'b0;
      end else if (bubble_s) begin
         rd_r      <= 5'd0;
         is_load_r <= 1'b0;
      end else begin
         rd_r      <= rd_ex_mem_i;
         alu_r     <= alu_out_ex_mem_i;
         pc_r      <= pc_ex_mem_i;
         wb_sel_r  <= wb_sel_ex_mem_i;
         is_load_r <= is_load_instr_ex_mem_i;
         rd_data_r <= is_load_instr_ex_mem_i ?
                      fmt_load(dmem_rdata_i, alu_out_ex_mem_i[1:0], funct3_ex_mem_i) :
                      32'd0;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   logic misalign_r;

   // One-cycle misalignment pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= misalign_fire_s;
      end
   end

   assign misalign_o = misalign_r;
`else
   assign misalign_o = 1'b0;
`endif

   assign busywait_o             = busywait_s;
   assign dmem_req_o             = req_r;
   assign dmem_we_o              = we_r;
   assign dmem_addr_o            = addr_r;
   assign dmem_wdata_o           = wdata_r;
   assign dmem_wstrb_o           = wstrb_r;
   assign bus_err_o              = bus_err_r;
   assign rd_mem_wb_o            = rd_r;
   assign alu_out_mem_wb_o       = alu_r;
   assign rd_data_mem_wb_o       = rd_data_r;
   assign pc_mem_wb_o            = pc_r;
   assign wb_sel_mem_wb_o        = wb_sel_r;
   assign is_load_instr_mem_wb_o = is_load_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// Self-checking bench for memory_access_stage. Each instruction is described
// at transaction level (kind, funct3, address, data, ack delay); the expected
// request fields, stall length and MEM/WB contents come from plain arithmetic
// on those values.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

   localparam int unsigned TO = 16;
   localparam int K_ALU = 0;
   localparam int K_LD  = 1;
   localparam int K_ST  = 2;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] alu_out_ex_mem_i;
   logic [31:0] rs2_ex_mem_i;
   logic [4:0]  rd_ex_mem_i;
   logic [31:0] pc_ex_mem_i;
   logic [1:0]  wb_sel_ex_mem_i;
   logic [2:0]  funct3_ex_mem_i;
   logic        is_load_instr_ex_mem_i;
   logic        is_store_instr_ex_mem_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [29:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;
   logic        busywait_o;
   logic [4:0]  rd_mem_wb_o;
   logic [31:0] alu_out_mem_wb_o;
   logic [31:0] rd_data_mem_wb_o;
   logic [31:0] pc_mem_wb_o;
   logic [1:0]  wb_sel_mem_wb_o;
   logic        is_load_instr_mem_wb_o;
   logic        bus_err_o;
   logic        misalign_o;

   int n_cmp  = 0;
   int n_fail = 0;

   memory_access_stage #(.ACK_TIMEOUT(TO)) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .alu_out_ex_mem_i        (alu_out_ex_mem_i),
      .rs2_ex_mem_i            (rs2_ex_mem_i),
      .rd_ex_mem_i             (rd_ex_mem_i),
      .pc_ex_mem_i             (pc_ex_mem_i),
      .wb_sel_ex_mem_i         (wb_sel_ex_mem_i),
      .funct3_ex_mem_i         (funct3_ex_mem_i),
      .is_load_instr_ex_mem_i  (is_load_instr_ex_mem_i),
      .is_store_instr_ex_mem_i (is_store_instr_ex_mem_i),
      .dmem_req_o              (dmem_req_o),
      .dmem_we_o               (dmem_we_o),
      .dmem_addr_o             (dmem_addr_o),
      .dmem_wdata_o            (dmem_wdata_o),
      .dmem_wstrb_o            (dmem_wstrb_o),
      .dmem_rdata_i            (dmem_rdata_i),
      .dmem_ack_i              (dmem_ack_i),
      .busywait_o              (busywait_o),
      .rd_mem_wb_o             (rd_mem_wb_o),
      .alu_out_mem_wb_o        (alu_out_mem_wb_o),
      .rd_data_mem_wb_o        (rd_data_mem_wb_o),
      .pc_mem_wb_o             (pc_mem_wb_o),
      .wb_sel_mem_wb_o         (wb_sel_mem_wb_o),
      .is_load_instr_mem_wb_o  (is_load_instr_mem_wb_o),
      .bus_err_o               (bus_err_o),
      .misalign_o              (misalign_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      logic [31:0] b;
      logic [31:0] h;
      b = (rdata >> (8 * (addr % 4))) & 32'h0000_00FF;
      h = (rdata >> (16 * ((addr / 2) % 2))) & 32'h0000_FFFF;
      case (f3)
         3'd0:    m_load = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    m_load = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    m_load = b;
         3'd5:    m_load = h;
         default: m_load = rdata;
      endcase
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
      case (f3)
         3'd0:    m_wstrb = 4'(32'd1 << (addr % 4));
         3'd1:    m_wstrb = 4'(32'd3 << (2 * ((addr / 2) % 2)));
         default: m_wstrb = 4'd15;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      case (f3)
         3'd0:    m_wdata = (rs2 % 256) * 32'h0101_0101;
         3'd1:    m_wdata = (rs2 % 65536) * 32'h0001_0001;
         default: m_wdata = rs2;
      endcase
   endfunction

   function automatic bit m_misaligned(input int kind, input logic [2:0] f3,
                                       input logic [31:0] addr);
      m_misaligned = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      if (kind != K_ALU) begin
         if (f3 == 3'd1 || f3 == 3'd5) m_misaligned = (addr % 2) != 0;
         else if (f3 != 3'd0 && f3 != 3'd4) m_misaligned = (addr % 4) != 0;
      end
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},    32'(dmem_req_o), 32'd0);
      check({tag, "_we"},     32'(dmem_we_o), 32'd0);
      check({tag, "_addr"},   32'(dmem_addr_o), 32'd0);
      check({tag, "_wdata"},  dmem_wdata_o, 32'd0);
      check({tag, "_wstrb"},  32'(dmem_wstrb_o), 32'd0);
      check({tag, "_rd"},     32'(rd_mem_wb_o), 32'd0);
      check({tag, "_alu"},    alu_out_mem_wb_o, 32'd0);
      check({tag, "_rddata"}, rd_data_mem_wb_o, 32'd0);
      check({tag, "_pc"},     pc_mem_wb_o, 32'd0);
      check({tag, "_wbsel"},  32'(wb_sel_mem_wb_o), 32'd0);
      check({tag, "_isld"},   32'(is_load_instr_mem_wb_o), 32'd0);
      check({tag, "_buserr"}, 32'(bus_err_o), 32'd0);
      check({tag, "_misal"},  32'(misalign_o), 32'd0);
   endtask

   task automatic drive_zero();
      alu_out_ex_mem_i        = 32'd0;
      rs2_ex_mem_i            = 32'd0;
      rd_ex_mem_i             = 5'd0;
      pc_ex_mem_i             = 32'd0;
      wb_sel_ex_mem_i         = 2'd0;
      funct3_ex_mem_i         = 3'd0;
      is_load_instr_ex_mem_i  = 1'b0;
      is_store_instr_ex_mem_i = 1'b0;
      dmem_rdata_i            = 32'd0;
      dmem_ack_i              = 1'b0;
   endtask

   // Runs one instruction through the stage; called at posedge+1.
   // delay = index of the WAIT cycle that carries ack (>= TO means never).
   task automatic run_instr(input string tag, input int kind, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] rdata, input logic [4:0] rd,
                            input int delay);
      logic [31:0] pc;
      logic [1:0]  wbs;
      bit          mis;
      bit          tmo;
      bit          done;
      bit          busy_prev;
      int          w;
      int          stall;
      int          exp_stall;
      int          exp_reqs;
      pc  = $urandom;
      wbs = 2'($urandom_range(0, 3));
      mis = m_misaligned(kind, f3, addr);
      tmo = (kind != K_ALU) && !mis && (delay >= int'(TO));
      if (kind == K_ALU || mis) begin
         exp_stall = 0;
         exp_reqs  = 0;
      end else if (tmo) begin
         exp_stall = int'(TO);
         exp_reqs  = int'(TO);
      end else begin
         exp_stall = delay + 1;
         exp_reqs  = delay + 1;
      end
      alu_out_ex_mem_i        = addr;
      rs2_ex_mem_i            = rs2;
      rd_ex_mem_i             = rd;
      pc_ex_mem_i             = pc;
      wb_sel_ex_mem_i         = wbs;
      funct3_ex_mem_i         = f3;
      is_load_instr_ex_mem_i  = (kind == K_LD);
      is_store_instr_ex_mem_i = (kind == K_ST);
      w = 0; stall = 0; done = 1'b0; busy_prev = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk_i);
         dmem_rdata_i = rdata;
         // outside WAIT a random ack is offered; the stage must ignore it
         dmem_ack_i = dmem_req_o ? (w == delay) : 1'($urandom_range(0, 1));
         #1;
         if (busy_prev) check({tag, "_bubble_rd"}, 32'(rd_mem_wb_o), 32'd0);
         if (dmem_req_o) begin
            check({tag, "_addr"},  32'(dmem_addr_o), addr / 4);
            check({tag, "_we"},    32'(dmem_we_o), 32'(kind == K_ST));
            check({tag, "_wstrb"}, 32'(dmem_wstrb_o),
                  (kind == K_ST) ? 32'(m_wstrb(f3, addr)) : 32'd0);
            if (kind == K_ST) check({tag, "_wdata"}, dmem_wdata_o, m_wdata(f3, rs2));
            w++;
         end
         if (busywait_o) begin
            stall++;
            busy_prev = 1'b1;
         end else begin
            done = 1'b1;
         end
         @(posedge clk_i);
         #1;
         dmem_ack_i = 1'b0;
      end
      check({tag, "_bound"}, 32'(done), 32'd1);
      check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
      check({tag, "_nreq"},  32'(w), 32'(exp_reqs));
      check({tag, "_reqoff"}, 32'(dmem_req_o), 32'd0);
      check({tag, "_buserr"}, 32'(bus_err_o), 32'(tmo));
      check({tag, "_misal"},  32'(misalign_o), 32'(mis));
      if (tmo || mis) begin
         check({tag, "_rd"},   32'(rd_mem_wb_o), 32'd0);
         check({tag, "_isld"}, 32'(is_load_instr_mem_wb_o), 32'd0);
      end else begin
         check({tag, "_rd"},    32'(rd_mem_wb_o), 32'(rd));
         check({tag, "_alu"},   alu_out_mem_wb_o, addr);
         check({tag, "_pc"},    pc_mem_wb_o, pc);
         check({tag, "_wbsel"}, 32'(wb_sel_mem_wb_o), 32'(wbs));
         check({tag, "_isld"},  32'(is_load_instr_mem_wb_o), 32'(kind == K_LD));
         check({tag, "_rddata"}, rd_data_mem_wb_o,
               (kind == K_LD) ? m_load(f3, addr, rdata) : 32'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          dly;

      rst_i = 1'b1;
      drive_zero();
      repeat (2) @(posedge clk_i);
      #1;
      check_all_zero("reset");
      rst_i = 1'b0;

      // directed cases
      run_instr("sb103",  K_ST,  3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 5'd3, 2);
      run_instr("lb102",  K_LD,  3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd4, 1);
      run_instr("lbu102", K_LD,  3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 5'd4, 1);
      run_instr("lh2",    K_LD,  3'b001, 32'h0000_0002, 32'h0, 32'h8001_1234, 5'd9, 0);
      run_instr("sw_to",  K_ST,  3'b010, 32'h0000_0200, 32'h1234_5678, 32'h0, 5'd1, 255);
      run_instr("lw_d15", K_LD,  3'b010, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 5'd2, 15);
      run_instr("add5",   K_ALU, 3'b000, 32'h0000_0011, 32'h0, 32'h0, 5'd5, 0);
      run_instr("lw6",    K_LD,  3'b010, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 5'd6, 0);
      run_instr("add7",   K_ALU, 3'b000, 32'h0000_0022, 32'h0, 32'h0, 5'd7, 0);
      run_instr("lw101",  K_LD,  3'b010, 32'h0000_0101, 32'h0, 32'h0BAD_BEEF, 5'd8, 1);
      run_instr("sh_hi",  K_ST,  3'b001, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 5'd0, 0);

      // reset while waiting for ack, then a late ack
      alu_out_ex_mem_i        = 32'h0000_0400;
      funct3_ex_mem_i         = 3'b010;
      rd_ex_mem_i             = 5'd12;
      is_load_instr_ex_mem_i  = 1'b1;
      @(posedge clk_i);
      #1;
      check("rstwait_req_up", 32'(dmem_req_o), 32'd1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      drive_zero();
      check_all_zero("rstwait");
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'hFFFF_FFFF;
      @(posedge clk_i);
      #1;
      dmem_ack_i = 1'b0;
      check_all_zero("lateack");

      // randomized instruction stream
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 2);
         if (kind == K_ST) f3 = 3'($urandom_range(0, 2));
         else              f3 = 3'($urandom_range(0, 7));
         addr = $urandom;
         dly  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
         run_instr($sformatf("rnd%0d", i), kind, f3, addr, $urandom, $urandom,
                   5'($urandom_range(1, 31)), dly);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
